// File: rtl/maxnet_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : maxnet_sequencer
// Purpose  : Time-multiplexes a single PU over the 4 neurons of a Maxnet.
//            For each neuron it presents the activation vector and the
//            neuron's weight row, pulses the PU multiplier and adder register
//            enables, then captures the PU result. After all 4 neurons it
//            updates the activations synchronously and repeats until at most
//            one neuron is non-zero or MAX_ITER iterations have run.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            start                     - begin a competition (IDLE/DONE only)
//            x_in0..3, w_self, w_other - initial activations and weights
//            pu_x0..3, pu_w0..3        - PU operands (activations, weight row)
//            mult_reg_en, add_reg_en   - PU pipeline register enables
//            pu_new_value, pu_zero     - PU result for the current neuron
//            busy, done, winner_idx, no_winner, timeout, iter_count
//                                      - status / result
//            x_out0..3                 - current activations
// Revision : 1.0 - initial release
// ============================================================================
module maxnet_sequencer #(
    parameter int WIDTH    = 5,
    parameter int MAX_ITER = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in0,
    input  logic [WIDTH-1:0] x_in1,
    input  logic [WIDTH-1:0] x_in2,
    input  logic [WIDTH-1:0] x_in3,
    input  logic [WIDTH-1:0] w_self,
    input  logic [WIDTH-1:0] w_other,
    output logic [WIDTH-1:0] pu_x0,
    output logic [WIDTH-1:0] pu_x1,
    output logic [WIDTH-1:0] pu_x2,
    output logic [WIDTH-1:0] pu_x3,
    output logic [WIDTH-1:0] pu_w0,
    output logic [WIDTH-1:0] pu_w1,
    output logic [WIDTH-1:0] pu_w2,
    output logic [WIDTH-1:0] pu_w3,
    output logic             mult_reg_en,
    output logic             add_reg_en,
    input  logic [WIDTH-1:0] pu_new_value,
    input  logic             pu_zero,
    output logic             busy,
    output logic             done,
    output logic [1:0]       winner_idx,
    output logic             no_winner,
    output logic             timeout,
    output logic [3:0]       iter_count,
    output logic [WIDTH-1:0] x_out0,
    output logic [WIDTH-1:0] x_out1,
    output logic [WIDTH-1:0] x_out2,
    output logic [WIDTH-1:0] x_out3
);

    localparam logic [4:0] c_max_iter = 5'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MULT  = 3'd2,
        S_ADD   = 3'd3,
        S_CAP   = 3'd4,
        S_CHECK = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a   [4];    // activations used by the current iteration
    logic [WIDTH-1:0] r_nxt [4];    // results collected during the iteration
    logic [3:0]       r_zmask;      // 1 = neuron reported zero this iteration
    logic [1:0]       r_n;          // neuron currently on the PU
    logic [3:0]       r_iter;
    logic [1:0]       r_winner;
    logic             r_no_winner;
    logic             r_timeout;

    logic [2:0]       w_nz_cnt;     // neurons still non-zero
    logic [1:0]       w_first_nz;   // lowest index still non-zero
    logic             w_last_iter;
    logic             w_mult_en;
    logic             w_add_en;
    logic [WIDTH-1:0] w_row [4];

    // ------------------------------------------------------------------
    // Survivor analysis of the just-completed iteration
    // ------------------------------------------------------------------
    always_comb begin
        w_nz_cnt   = 3'd0;
        w_first_nz = 2'd0;
        // Walk downward so the last hit is the lowest index
        for (int i = 3; i >= 0; i--) begin
            if (!r_zmask[i]) begin
                w_nz_cnt   = w_nz_cnt + 3'd1;
                w_first_nz = 2'(i);
            end
        end
    end

    assign w_last_iter = (({1'b0, r_iter} + 5'd1) == c_max_iter);

    // ------------------------------------------------------------------
    // Next-state and enable decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_mult_en    = 1'b0;
        w_add_en     = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_MULT;
            S_MULT: begin
                w_mult_en    = 1'b1;
                w_next_state = S_ADD;
            end
            S_ADD: begin
                w_add_en     = 1'b1;
                w_next_state = S_CAP;
            end
            S_CAP:   w_next_state = (r_n == 2'd3) ? S_CHECK : S_MULT;
            S_CHECK: w_next_state = ((w_nz_cnt <= 3'd1) || w_last_iter) ? S_DONE : S_MULT;
            S_DONE:  if (start) w_next_state = S_LOAD;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                r_a[i]   <= '0;
                r_nxt[i] <= '0;
            end
            r_zmask     <= 4'd0;
            r_n         <= 2'd0;
            r_iter      <= 4'd0;
            r_winner    <= 2'd0;
            r_no_winner <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_winner    <= 2'd0;
                        r_no_winner <= 1'b0;
                        r_timeout   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_a[0] <= x_in0;
                    r_a[1] <= x_in1;
                    r_a[2] <= x_in2;
                    r_a[3] <= x_in3;
                    r_n    <= 2'd0;
                    r_iter <= 4'd0;
                end
                S_CAP: begin
                    r_nxt[r_n]   <= pu_new_value;
                    r_zmask[r_n] <= pu_zero;
                    r_n          <= r_n + 2'd1;
                end
                S_CHECK: begin
                    // All four neurons were computed from the old r_a
                    for (int i = 0; i < 4; i++) begin
                        r_a[i] <= r_nxt[i];
                    end
                    if ({1'b0, r_iter} < c_max_iter) begin
                        r_iter <= r_iter + 4'd1;
                    end
                    if (w_nz_cnt <= 3'd1) begin
                        r_no_winner <= (w_nz_cnt == 3'd0);
                        r_winner    <= (w_nz_cnt == 3'd0) ? 2'd0 : w_first_nz;
                    end else if (w_last_iter) begin
                        r_timeout <= 1'b1;
                        r_winner  <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Weight row for the neuron on the PU: diagonal gets w_self
    // ------------------------------------------------------------------
    for (genvar j = 0; j < 4; j++) begin : g_row
        assign w_row[j] = (r_n == 2'(j)) ? w_self : w_other;
    end

    assign pu_w0       = w_row[0];
    assign pu_w1       = w_row[1];
    assign pu_w2       = w_row[2];
    assign pu_w3       = w_row[3];

    assign pu_x0       = r_a[0];
    assign pu_x1       = r_a[1];
    assign pu_x2       = r_a[2];
    assign pu_x3       = r_a[3];
    assign x_out0      = r_a[0];
    assign x_out1      = r_a[1];
    assign x_out2      = r_a[2];
    assign x_out3      = r_a[3];

    assign mult_reg_en = w_mult_en;
    assign add_reg_en  = w_add_en;
    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done        = (r_state == S_DONE);
    assign winner_idx  = r_winner;
    assign no_winner   = r_no_winner;
    assign timeout     = r_timeout;
    assign iter_count  = r_iter;

endmodule
`default_nettype wire
